// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 codes, FSM state encoding and operand signedness helpers.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic aIsSigned(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic bIsSigned(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX-stage pipeline and the M unit.
interface muldiv_unit_if #(
  parameter int XLEN = muldiv_pkg::XLEN_DEFAULT
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busywait;

  modport master (
    output start, funct3, operand_a, operand_b,
    input  result, done, busywait
  );

  modport slave (
    input  start, funct3, operand_a, operand_b,
    output result, done, busywait
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] partRem_i,
  input  logic            dividendBit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] nextRem_o,
  output logic            qBit_o
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // partRem < divisor always holds, so the top bit of trial is a clean borrow flag
  assign shifted   = {partRem_i, dividendBit_i};
  assign trial     = shifted - {1'b0, divisor_i};
  assign qBit_o    = ~trial[XLEN];
  assign nextRem_o = qBit_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a stall/done handshake.
// Define FAST_MUL_EN to compute all multiplies in one cycle with a 33x33 multiplier.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int DIV_STEPS = XLEN
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(DIV_STEPS);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opB_q, opB_d, result_q, result_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            negRes_q, negRes_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept, aNeg, bNeg, divZero, overflow, skipRun, cntLast, qBit;
  logic [XLEN-1:0] magA, magB, divRem, divSel;
  logic [XLEN:0]   mulSum;
  logic [2*XLEN-1:0] prodAdj;

  assign accept  = bus.start && (state_q == IDLE || state_q == DONE);
  assign aNeg    = aIsSigned(bus.funct3) && bus.operand_a[XLEN-1];
  assign bNeg    = bIsSigned(bus.funct3) && bus.operand_b[XLEN-1];
  assign magA    = aNeg ? -bus.operand_a : bus.operand_a;
  assign magB    = bNeg ? -bus.operand_b : bus.operand_b;
  assign divZero = bus.funct3[2] && (bus.operand_b == '0);
  assign overflow = bus.funct3[2] && !bus.funct3[0] &&
                    (bus.operand_a == MIN_NEG) && (bus.operand_b == '1);
  assign cntLast = (cnt_q == CW'(DIV_STEPS - 1));

`ifdef FAST_MUL_EN
  logic signed [XLEN:0]     fastA, fastB;
  logic signed [2*XLEN+1:0] fastProd;
  assign fastA    = {aIsSigned(bus.funct3) && bus.operand_a[XLEN-1], bus.operand_a};
  assign fastB    = {bIsSigned(bus.funct3) && bus.operand_b[XLEN-1], bus.operand_b};
  assign fastProd = fastA * fastB;
  assign skipRun  = divZero || overflow || !bus.funct3[2];
`else
  assign skipRun  = divZero || overflow;
`endif

  div_step #(.XLEN(XLEN)) u_divStep (
    .partRem_i     (hi_q),
    .dividendBit_i (lo_q[XLEN-1]),
    .divisor_i     (opB_q),
    .nextRem_o     (divRem),
    .qBit_o        (qBit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = skipRun ? FIX : RUN;
      RUN:     if (cntLast)   state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = bus.start ? (skipRun ? FIX : RUN) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.done     = (state_q == DONE);
    bus.busywait = !reset && ((state_q == IDLE && bus.start) || state_q == RUN || state_q == FIX);
    bus.result   = result_q;
  end

  // Shared datapath: multiply keeps the product in {hi,lo}; divide keeps remainder in hi, quotient in lo
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opB_d    = opB_q;
    funct3_d = funct3_q;
    negRes_d = negRes_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    mulSum   = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opB_q}) : {1'b0, hi_q};
    prodAdj  = negRes_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    divSel   = funct3_q[1] ? hi_q : lo_q;

    if (accept) begin
      funct3_d = bus.funct3;
      cnt_d    = '0;
      negRes_d = 1'b0;
      if (divZero) begin
        hi_d = bus.operand_a;
        lo_d = '1;
      end else if (overflow) begin
        hi_d = '0;
        lo_d = MIN_NEG;
`ifdef FAST_MUL_EN
      end else if (!bus.funct3[2]) begin
        {hi_d, lo_d} = fastProd[2*XLEN-1:0];
`endif
      end else if (bus.funct3[2]) begin
        hi_d     = '0;
        lo_d     = magA;
        opB_d    = magB;
        negRes_d = bus.funct3[1] ? aNeg : (aNeg ^ bNeg);
      end else begin
        hi_d     = '0;
        lo_d     = magB;
        opB_d    = magA;
        negRes_d = aNeg ^ bNeg;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      if (funct3_q[2]) begin
        hi_d = divRem;
        lo_d = {lo_q[XLEN-2:0], qBit};
      end else begin
        hi_d = mulSum[XLEN:1];
        lo_d = {mulSum[0], lo_q[XLEN-1:1]};
      end
    end else if (state_q == FIX) begin
      if (funct3_q[2])             result_d = negRes_q ? -divSel : divSel;
      else if (funct3_q == F3_MUL) result_d = prodAdj[XLEN-1:0];
      else                         result_d = prodAdj[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opB_q    <= '0;
      funct3_q <= '0;
      negRes_q <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opB_q    <= opB_d;
      funct3_q <= funct3_d;
      negRes_q <= negRes_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
endmodule
